mem_port_arbiter: RTL and testbench

//  Shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch port and its data-memory port.

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port fixed-latency memory between instruction fetch and data access.
// Data port wins unless fetch has waited through STARVE consecutive data grants.
//
// state  | meaning
// IDLE   | no access outstanding; grant on any pending request
// ACCESS | access issued, counting LAT+1 cycles to completion; may re-grant on the final edge
module mem_port_arbiter #(
   parameter int N      = 32,
   parameter int LAT    = 2,
   parameter int STARVE = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         if_req,
   input  logic [N-1:0] if_addr,
   output logic [N-1:0] if_rdata,
   output logic         if_valid,
   output logic         if_stall,
   input  logic         dm_req,
   input  logic         dm_we,
   input  logic [N-1:0] dm_addr,
   input  logic [N-1:0] dm_wdata,
   output logic [N-1:0] dm_rdata,
   output logic         dm_valid,
   output logic         dm_stall,
   output logic         mem_en,
   output logic         mem_we,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   input  logic [N-1:0] mem_rdata
);

   localparam int WW = $clog2(LAT + 1);
   localparam int SW = $clog2(STARVE + 1);
   localparam logic [WW-1:0] LAT_W    = WW'(LAT);
   localparam logic [SW-1:0] STARVE_W = SW'(STARVE);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t        state, state_nx;
   logic [WW-1:0] wait_cnt, wait_nx;
   logic [SW-1:0] starve, starve_nx;
   logic          gnt_dm, gnt_dm_nx;
   logic          gnt_we, gnt_we_nx;
   logic          mem_en_q, mem_en_nx;
   logic          mem_we_q, mem_we_nx;
   logic [N-1:0]  mem_addr_q, mem_addr_nx;
   logic [N-1:0]  mem_wdata_q, mem_wdata_nx;
   logic [N-1:0]  if_rdata_q, dm_rdata_q;
   logic          done, pick_dm, issue;

   always_comb begin
      done    = (state == ACCESS) && (wait_cnt == LAT_W);
      pick_dm = dm_req && !(if_req && (starve == STARVE_W));
      issue   = ((state == IDLE) || done) && (dm_req || if_req);
   end

   always_comb begin
      state_nx     = state;
      wait_nx      = wait_cnt;
      starve_nx    = starve;
      gnt_dm_nx    = gnt_dm;
      gnt_we_nx    = gnt_we;
      mem_en_nx    = 1'b0;
      mem_we_nx    = 1'b0;
      mem_addr_nx  = '0;
      mem_wdata_nx = '0;
      case (state)
         IDLE: begin
            if (issue) begin
               state_nx = ACCESS;
               wait_nx  = '0;
            end
         end
         ACCESS: begin
            wait_nx = wait_cnt + 1'b1;
            if (done) begin
               state_nx = issue ? ACCESS : IDLE;
               wait_nx  = '0;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (issue) begin
         gnt_dm_nx    = pick_dm;
         gnt_we_nx    = pick_dm & dm_we;
         mem_en_nx    = 1'b1;
         mem_we_nx    = pick_dm & dm_we;
         mem_addr_nx  = pick_dm ? dm_addr : if_addr;
         mem_wdata_nx = pick_dm ? dm_wdata : '0;
         if (pick_dm && if_req)
            starve_nx = (starve == STARVE_W) ? starve : starve + 1'b1;
         else
            starve_nx = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         starve      <= '0;
         gnt_dm      <= 1'b0;
         gnt_we      <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         state       <= state_nx;
         wait_cnt    <= wait_nx;
         starve      <= starve_nx;
         gnt_dm      <= gnt_dm_nx;
         gnt_we      <= gnt_we_nx;
         mem_en_q    <= mem_en_nx;
         mem_we_q    <= mem_we_nx;
         mem_addr_q  <= mem_addr_nx;
         mem_wdata_q <= mem_wdata_nx;
         if (done && !gnt_we) begin
            if (gnt_dm) dm_rdata_q <= mem_rdata;
            else        if_rdata_q <= mem_rdata;
         end
      end
   end

   // Read data is forwarded during the valid cycle and held afterwards; rst forces every output low.
   assign if_valid  = done & ~gnt_dm & ~rst;
   assign dm_valid  = done & gnt_dm & ~rst;
   assign if_rdata  = if_valid ? mem_rdata : if_rdata_q;
   assign dm_rdata  = (dm_valid & ~gnt_we) ? mem_rdata : dm_rdata_q;
   assign if_stall  = if_req & ~if_valid & ~rst;
   assign dm_stall  = dm_req & ~dm_valid & ~rst;
   assign mem_en    = mem_en_q & ~rst;
   assign mem_we    = mem_we_q & ~rst;
   assign mem_addr  = rst ? '0 : mem_addr_q;
   assign mem_wdata = rst ? '0 : mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected issues and completions,
// a monitor compares them against what the arbiter presents, cycle by cycle.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, dm_req, dm_we;
   logic [31:0] if_addr, dm_addr, dm_wdata;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        if_valid, if_stall, dm_valid, dm_stall, mem_en, mem_we;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      int          cyc;
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t q_issue[$];
   exp_t q_if[$];
   exp_t q_dm[$];

   mem_port_arbiter #(.N(32), .LAT(2), .STARVE(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_valid(if_valid), .if_stall(if_stall),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mval(input logic [31:0] a);
      if (a == 32'h10) return 32'h00A0_0093;
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   // Memory model: read data appears two cycles after the mem_en cycle.
   logic [1:0]  pv = 2'b00;
   logic [31:0] pa0 = '0, pa1 = '0;
   always @(posedge clk) begin
      pv  <= {pv[0], mem_en & ~mem_we};
      pa0 <= mem_addr;
      pa1 <= pa0;
   end
   assign mem_rdata = pv[1] ? mval(pa1) : 32'hBAD0_BAD0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " mem_en"}, 32'(mem_en), 32'h0);
      chk({tag, " mem_we"}, 32'(mem_we), 32'h0);
      chk({tag, " mem_addr"}, mem_addr, 32'h0);
      chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
      chk({tag, " if_valid"}, 32'(if_valid), 32'h0);
      chk({tag, " dm_valid"}, 32'(dm_valid), 32'h0);
      chk({tag, " if_stall"}, 32'(if_stall), 32'h0);
      chk({tag, " dm_stall"}, 32'(dm_stall), 32'h0);
      chk({tag, " if_rdata"}, if_rdata, 32'h0);
      chk({tag, " dm_rdata"}, dm_rdata, 32'h0);
   endtask

   task automatic push_issue(input int c, input logic we, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.cyc = c; e.we = we; e.addr = a; e.data = d;
      q_issue.push_back(e);
   endtask

   task automatic push_rd(input bit is_dm, input int c, input logic [31:0] d);
      exp_t e;
      e.cyc = c; e.we = 1'b0; e.addr = '0; e.data = d;
      if (is_dm) q_dm.push_back(e);
      else       q_if.push_back(e);
   endtask

   task automatic wait_to(input int n);
      while (cyc < n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mem_en) begin
            if (q_issue.size() == 0) begin
               chk("unexpected mem_en", 32'(mem_en), 32'h0);
            end else begin
               e = q_issue.pop_front();
               chk("issue cycle", 32'(cyc), 32'(e.cyc));
               chk("mem_we", 32'(mem_we), 32'(e.we));
               chk("mem_addr", mem_addr, e.addr);
               chk("mem_wdata", mem_wdata, e.data);
            end
         end else begin
            chk("idle mem bus", {31'(mem_addr | mem_wdata), mem_we}, 32'h0);
         end
         if (if_valid) begin
            if (q_if.size() == 0) begin
               chk("unexpected if_valid", 32'(if_valid), 32'h0);
            end else begin
               e = q_if.pop_front();
               chk("if_valid cycle", 32'(cyc), 32'(e.cyc));
               chk("if_rdata", if_rdata, e.data);
            end
         end
         if (dm_valid) begin
            if (q_dm.size() == 0) begin
               chk("unexpected dm_valid", 32'(dm_valid), 32'h0);
            end else begin
               e = q_dm.pop_front();
               chk("dm_valid cycle", 32'(cyc), 32'(e.cyc));
               chk("dm_rdata", dm_rdata, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      int c;
      rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      @(negedge clk); #1;

      // Reset held with both requests pending
      if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_addr = 32'h20;
      repeat (2) begin
         @(negedge clk);
         check_zero("reset");
      end
      #1;
      rst = 1'b0;
      c = cyc;
      push_issue(c + 1, 1'b0, 32'h20, 32'h0);
      push_rd(1'b1, c + 3, mval(32'h20));
      wait_to(c + 3);
      dm_req = 1'b0;
      push_issue(c + 4, 1'b0, 32'h10, 32'h0);
      push_rd(1'b0, c + 6, 32'h00A0_0093);
      wait_to(c + 6);
      if_req = 1'b0;

      // Fetch only, with stall profile
      wait_to(cyc + 1);
      c = cyc;
      if_req = 1'b1; if_addr = 32'h10;
      push_issue(c + 1, 1'b0, 32'h10, 32'h0);
      push_rd(1'b0, c + 3, 32'h00A0_0093);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("if_stall", 32'(if_stall), (k < 3) ? 32'h1 : 32'h0);
         #1;
      end
      if_req = 1'b0;

      // Simultaneous requests: data first, fetch next
      wait_to(cyc + 1);
      c = cyc;
      if_req = 1'b1; if_addr = 32'h14; dm_req = 1'b1; dm_addr = 32'h80;
      push_issue(c + 1, 1'b0, 32'h80, 32'h0);
      push_rd(1'b1, c + 3, mval(32'h80));
      push_issue(c + 4, 1'b0, 32'h14, 32'h0);
      push_rd(1'b0, c + 6, mval(32'h14));
      wait_to(c + 3);
      dm_req = 1'b0;
      wait_to(c + 6);
      if_req = 1'b0;

      // Store: dm_rdata keeps the previous load value
      wait_to(cyc + 1);
      c = cyc;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
      push_issue(c + 1, 1'b1, 32'h40, 32'hDEAD_BEEF);
      push_rd(1'b1, c + 3, mval(32'h80));
      wait_to(c + 3);
      dm_req = 1'b0; dm_we = 1'b0; dm_wdata = '0;

      // Starvation: both held, fetch every fifth grant
      wait_to(cyc + 1);
      c = cyc;
      dm_req = 1'b1; dm_addr = 32'h100; if_req = 1'b1; if_addr = 32'h200;
      for (int k = 0; k < 10; k++) begin
         if (k % 5 == 4) begin
            push_issue(c + 1 + 3 * k, 1'b0, 32'h200, 32'h0);
            push_rd(1'b0, c + 3 + 3 * k, mval(32'h200));
         end else begin
            push_issue(c + 1 + 3 * k, 1'b0, 32'h100, 32'h0);
            push_rd(1'b1, c + 3 + 3 * k, mval(32'h100));
         end
      end
      wait_to(c + 30);
      dm_req = 1'b0; if_req = 1'b0;

      // Reset in the first access cycle, then a clean fetch
      wait_to(cyc + 1);
      c = cyc;
      if_req = 1'b1; if_addr = 32'h30;
      push_issue(c + 1, 1'b0, 32'h30, 32'h0);
      wait_to(c + 1);
      rst = 1'b1;
      @(negedge clk);
      check_zero("mid reset");
      #1;
      rst = 1'b0;
      push_issue(c + 3, 1'b0, 32'h30, 32'h0);
      push_rd(1'b0, c + 5, mval(32'h30));
      wait_to(c + 5);
      if_req = 1'b0;

      wait_to(cyc + 4);
      chk("issue queue drained", 32'(q_issue.size()), 32'h0);
      chk("if queue drained", 32'(q_if.size()), 32'h0);
      chk("dm queue drained", 32'(q_dm.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
